crop_stream_arbiter: RTL and testbench
======================================

// Module: crop_stream_arbiter
// PURPOSE
//  Shares one downstream pixel consumer (Gaussian filter stage) between NUM_CROPS crop_plus_fifo
//  output streams. Grants one crop stream for a full OUT_ROWS*OUT_COLS window, never interleaving
//  windows, then re-arbitrates round-robin. Tags each forwarded pixel with its crop id and marks the
//  last pixel of each window.
// PARAMETERS
//  PIXEL_BIT_WIDTH  16    pixel word width (matches crop datapath)
//  NUM_CROPS        4     number of requesting crop streams (>=2)
//  OUT_ROWS         48    crop window rows
//  OUT_COLS         48    crop window cols; window length WIN = OUT_ROWS*OUT_COLS
//  TIMEOUT_CYCLES   1024  watchdog stall limit (used only with CROP_ARB_WATCHDOG_EN)
// PORTS
//  clk          in   1                          clock
//  reset        in   1                          synchronous, active-high reset
//  in_pixel     in   NUM_CROPS*PIXEL_BIT_WIDTH  packed pixels; stream k at [k*PBW +: PBW]
//  in_valid     in   NUM_CROPS                  per-stream valid
//  in_ready     out  NUM_CROPS                  per-stream ready
//  out_pixel    out  PIXEL_BIT_WIDTH            forwarded pixel
//  out_valid    out  1                          downstream valid
//  out_ready    in   1                          downstream ready
//  out_crop_id  out  max(1,$clog2(NUM_CROPS))   id of granted stream
//  out_last     out  1                          high with final pixel (index WIN-1) of a window
//  err_timeout  out  1                          sticky watchdog flag (tied 0 without macro)
// BEHAVIOUR
//  - Handshake: transfer when valid&&ready, on either side. Valid never depends on ready.
//  - FSM, 2 states:
//    IDLE : out_valid=0, in_ready=0. If |in_valid, grant = first k with in_valid[k], searching
//           ptr, ptr+1, ... mod NUM_CROPS. Grant, crop_id and cnt=0 register; next cycle -> BURST.
//    BURST: combinational pass-through of granted stream g: out_pixel=in_pixel[g], out_valid=
//           in_valid[g], in_ready[g]=out_ready, in_ready[others]=0. cnt++ per out handshake.
//           Handshake with cnt==WIN-1: out_last=1 (comb.), ptr<=(g+1)%NUM_CROPS, -> IDLE.
//  - Exactly one bubble cycle (IDLE) between windows. Grant cost: 1 cycle after request seen.
//  - Requests during BURST wait (in_ready low); fairness: a continuously requesting stream is
//    granted within NUM_CROPS-1 windows.
//  - cnt width $clog2(WIN+1); no wrap inside a window; cnt cleared on every grant.
//  - out_crop_id and out_pixel hold last granted value in IDLE (don't-care, out_valid=0).
//  - Reset (any state, incl. mid-burst): state=IDLE, ptr=0, cnt=0, grant=0, out_valid=0,
//    in_ready=0, out_last=0, err_timeout=0; partial window abandoned, no pixel consumed that cycle.
// CONFIGURATION
//  - `define CROP_ARB_WATCHDOG_EN: stall counter counts consecutive BURST cycles with
//    in_valid[g]=0; reaching TIMEOUT_CYCLES: set err_timeout (sticky until reset), ptr<=(g+1)%N,
//    -> IDLE, truncated window never flagged out_last. Counter clears on any in_valid[g]=1.
//  - Without macro: no stall counter, burst waits indefinitely, err_timeout tied 0.
// TESTING (NUM_CROPS=4, OUT_ROWS=OUT_COLS=4, WIN=16, TIMEOUT_CYCLES=32)
//  - Reset, all in_valid=0 -> out_valid=0, in_ready=0000 indefinitely; err_timeout=0.
//  - Only stream 2 valid, pixels 0..15, out_ready=1 -> out_crop_id=2, 16 pixels in order, out_last
//    on pixel 15 only, then 1 IDLE cycle, new window granted to stream 2 again.
//  - All 4 streams valid constantly -> window order 0,1,2,3,0; no pixel of different ids within a
//    window; in_ready[k]=0 for non-granted k every cycle.
//  - Random out_ready and in_valid on granted stream (50%) -> output equals stream data exactly,
//    count 16 per window, out_valid never drops while out_ready low.
//  - Reset asserted after 7 pixels of stream 1 -> next cycle IDLE, ptr=0; stream 0 granted first.
//  - WATCHDOG_EN: stream 3 sends 5 pixels then stalls -> 32 cycles later err_timeout=1 (sticky),
//    IDLE, next grant stream 0; without macro the burst remains on stream 3.

Source files
------------

// File: rtl/crop_stream_arbiter.sv
// Round-robin arbiter that shares one pixel consumer between NUM_CROPS crop streams, one full window per grant.
// Optional stall watchdog is enabled with `define CROP_ARB_WATCHDOG_EN.
module crop_stream_arbiter #(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int NUM_CROPS       = 4,
  parameter int OUT_ROWS        = 48,
  parameter int OUT_COLS        = 48,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_CROPS*PIXEL_BIT_WIDTH-1:0]         in_pixel,
  input  logic [NUM_CROPS-1:0]                         in_valid,
  output logic [NUM_CROPS-1:0]                         in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0]                   out_pixel,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [((NUM_CROPS>1)?$clog2(NUM_CROPS):1)-1:0] out_crop_id,
  output logic                                         out_last,
  output logic                                         err_timeout
);

  localparam int ID_W  = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1;
  localparam int WIN   = OUT_ROWS * OUT_COLS;
  localparam int CNT_W = $clog2(WIN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_CROPS - 1);
  localparam logic [ID_W:0]    NC_EXT   = (ID_W+1)'(NUM_CROPS);

  generate
    if (NUM_CROPS < 2 || TIMEOUT_CYCLES < 1 || WIN < 1) begin : g_bad_params
      $error("crop_stream_arbiter: invalid parameter set");
    end
  endgenerate

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 r_state, w_next;
  logic [ID_W-1:0]        r_ptr, r_grant, w_pick, w_off, w_grant_inc;
  logic [ID_W:0]          w_sum;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_CROPS-1:0]   w_rot;
  logic                   w_any, w_hs, w_win_done, w_timeout;

  assign w_any       = |in_valid;
  assign w_hs        = out_valid && out_ready;
  assign w_win_done  = w_hs && (r_cnt == LAST_IDX);
  assign w_grant_inc = (r_grant == LAST_ID) ? '0 : r_grant + ID_W'(1);

  // Rotate requests so bit 0 is the pointer position; the lowest set bit is the winner's offset.
  assign w_rot = NUM_CROPS'({in_valid, in_valid} >> r_ptr);

  always_comb begin
    w_off = '0;
    for (int i = NUM_CROPS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = ID_W'(i);
    end
  end

  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_pick = (w_sum >= NC_EXT) ? ID_W'(w_sum - NC_EXT) : w_sum[ID_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = BURST;
      BURST:   if (w_win_done || w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held so a half-finished window consumes nothing that cycle.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = '0;
    out_last  = 1'b0;
    if (!reset && r_state == BURST) begin
      out_valid         = in_valid[r_grant];
      in_ready[r_grant] = out_ready;
      out_last          = in_valid[r_grant] && (r_cnt == LAST_IDX);
    end
  end

  assign out_pixel   = in_pixel[r_grant*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
  assign out_crop_id = r_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_grant <= w_pick;
        r_cnt   <= '0;
      end
    end else begin
      if (w_hs) r_cnt <= r_cnt + CNT_W'(1);
      if (w_win_done || w_timeout) r_ptr <= w_grant_inc;
    end
  end

`ifdef CROP_ARB_WATCHDOG_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_err;

  // Abandon a window whose granted stream has gone silent for TIMEOUT_CYCLES consecutive cycles.
  assign w_timeout = (r_state == BURST) && !in_valid[r_grant] &&
                     (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state != BURST || in_valid[r_grant] || w_timeout) r_stall <= '0;
      else                                                   r_stall <= r_stall + STALL_W'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err_timeout = r_err;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_crop_stream_arbiter.sv
// Directed testbench for crop_stream_arbiter: 4 streams, 4x4 windows, watchdog limit 32.
// Stream k sends pixel {k, seq}; outputs are sampled on the falling edge, inputs change 1ns after the rising edge.
module tb_crop_stream_arbiter;

  localparam int PBW = 16;
  localparam int NC  = 4;
  localparam int WIN = 16;
  localparam int TMO = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NC*PBW-1:0] inPixel;
  logic [NC-1:0]   inValid = '0;
  logic [NC-1:0]   inReady;
  logic [PBW-1:0]  outPixel;
  logic            outValid;
  logic            outReady = 1'b0;
  logic [1:0]      outCropId;
  logic            outLast;
  logic            errTimeout;

  logic [7:0]      srcSeq [NC];
  int              nChecks = 0;
  int              nPass   = 0;

  logic            sValid, sRdy, sHs, sLast, sErr;
  logic [NC-1:0]   sInr;
  logic [PBW-1:0]  sPx;
  logic [1:0]      sId;

  for (genvar k = 0; k < NC; k++) begin : g_src
    assign inPixel[k*PBW +: PBW] = {8'(k), srcSeq[k]};
  end

  always #5 clk = ~clk;

  crop_stream_arbiter #(
    .PIXEL_BIT_WIDTH(PBW), .NUM_CROPS(NC), .OUT_ROWS(4), .OUT_COLS(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .in_pixel(inPixel), .in_valid(inValid), .in_ready(inReady),
    .out_pixel(outPixel), .out_valid(outValid), .out_ready(outReady), .out_crop_id(outCropId),
    .out_last(outLast), .err_timeout(errTimeout)
  );

  // One clock cycle: capture outputs mid-cycle, then advance the stream that handshaked.
  task automatic tick();
    @(negedge clk);
    sValid = outValid;
    sRdy   = outReady;
    sInr   = inReady;
    sPx    = outPixel;
    sId    = outCropId;
    sLast  = outLast;
    sErr   = errTimeout;
    sHs    = outValid && outReady;
    @(posedge clk);
    #1;
    if (sHs) srcSeq[sId] = srcSeq[sId] + 8'd1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    inValid  = '0;
    outReady = 1'b0;
    for (int k = 0; k < NC; k++) srcSeq[k] = 8'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tick();
      nChecks++;
      if (sValid !== 1'b0 || sInr !== 4'b0000 || sErr !== 1'b0)
        $display("[TB] FAIL reset_idle cyc %0d: got valid=%b ready=%b err=%b want 0/0000/0", c, sValid, sInr, sErr);
      else nPass++;
    end
  endtask

  task automatic test_single_stream();
    logic [15:0] e;
    do_reset();
    inValid  = 4'b0100;
    outReady = 1'b1;
    tick();
    nChecks++;
    if (sValid !== 1'b0) $display("[TB] FAIL single_grant_bubble: got valid=%b want 0", sValid);
    else nPass++;
    for (int p = 0; p < WIN; p++) begin
      tick();
      e = {8'd2, 8'(p)};
      nChecks++;
      if (sHs !== 1'b1 || sId !== 2'd2 || sPx !== e || sInr !== 4'b0100)
        $display("[TB] FAIL single_pixel %0d: got hs=%b id=%0d px=%h rdy=%b want 1/2/%h/0100", p, sHs, sId, sPx, sInr, e);
      else nPass++;
      nChecks++;
      if (sLast !== (p == WIN - 1))
        $display("[TB] FAIL single_last %0d: got %b want %b", p, sLast, (p == WIN - 1));
      else nPass++;
    end
    tick();
    nChecks++;
    if (sValid !== 1'b0) $display("[TB] FAIL single_between_bubble: got valid=%b want 0", sValid);
    else nPass++;
    tick();
    nChecks++;
    if (sHs !== 1'b1 || sId !== 2'd2 || sPx !== 16'h0210 || sLast !== 1'b0)
      $display("[TB] FAIL single_regrant: got hs=%b id=%0d px=%h last=%b want 1/2/0210/0", sHs, sId, sPx, sLast);
    else nPass++;
  endtask

  task automatic test_all_streams();
    int          order [5] = '{0, 1, 2, 3, 0};
    logic [15:0] e;
    logic [3:0]  er;
    int          seq;
    do_reset();
    inValid  = 4'hF;
    outReady = 1'b1;
    for (int w = 0; w < 5; w++) begin
      tick();
      nChecks++;
      if (sValid !== 1'b0) $display("[TB] FAIL rr_bubble win %0d: got valid=%b want 0", w, sValid);
      else nPass++;
      for (int p = 0; p < WIN; p++) begin
        tick();
        seq = (w == 4) ? WIN + p : p;
        e   = {8'(order[w]), 8'(seq)};
        er  = 4'(1 << order[w]);
        nChecks++;
        if (sHs !== 1'b1 || sId !== 2'(order[w]) || sPx !== e)
          $display("[TB] FAIL rr_pixel win %0d pix %0d: got hs=%b id=%0d px=%h want 1/%0d/%h", w, p, sHs, sId, sPx, order[w], e);
        else nPass++;
        nChecks++;
        if (sInr !== er || sLast !== (p == WIN - 1))
          $display("[TB] FAIL rr_ready_last win %0d pix %0d: got rdy=%b last=%b want %b/%b", w, p, sInr, sLast, er, (p == WIN - 1));
        else nPass++;
      end
    end
  endtask

  task automatic test_random_flow();
    int         wins = 0;
    int         cnt  = 0;
    logic [7:0] expSeq = 8'd0;
    logic       prevStall = 1'b0;
    do_reset();
    inValid[0] = 1'($urandom_range(0, 1));
    outReady   = 1'($urandom_range(0, 1));
    for (int c = 0; c < 600 && wins < 3; c++) begin
      tick();
      if (prevStall) begin
        nChecks++;
        if (sValid !== 1'b1) $display("[TB] FAIL rand_valid_hold cyc %0d: got %b want 1", c, sValid);
        else nPass++;
      end
      if (sHs) begin
        nChecks++;
        if (sId !== 2'd0 || sPx !== {8'd0, expSeq} || sLast !== (cnt == WIN - 1))
          $display("[TB] FAIL rand_pixel cyc %0d: got id=%0d px=%h last=%b want 0/%h/%b", c, sId, sPx, sLast, {8'd0, expSeq}, (cnt == WIN - 1));
        else nPass++;
        expSeq = expSeq + 8'd1;
        if (cnt == WIN - 1) begin
          wins++;
          cnt = 0;
        end else cnt++;
      end
      prevStall = sValid && !sRdy;
      if (!(inValid[0] && !sHs)) inValid[0] = 1'($urandom_range(0, 1));
      outReady = 1'($urandom_range(0, 1));
    end
    nChecks++;
    if (wins != 3) $display("[TB] FAIL rand_windows_done: got %0d want 3 within budget", wins);
    else nPass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    inValid  = 4'b0001;
    outReady = 1'b1;
    for (int c = 0; c < WIN + 1; c++) tick();
    inValid = 4'b0010;
    tick();
    nChecks++;
    if (sValid !== 1'b0) $display("[TB] FAIL mid_bubble: got valid=%b want 0", sValid);
    else nPass++;
    for (int p = 0; p < 7; p++) begin
      tick();
      nChecks++;
      if (sHs !== 1'b1 || sId !== 2'd1 || sPx !== {8'd1, 8'(p)})
        $display("[TB] FAIL mid_pixel %0d: got hs=%b id=%0d px=%h want 1/1/%h", p, sHs, sId, sPx, {8'd1, 8'(p)});
      else nPass++;
    end
    reset   = 1'b1;
    inValid = 4'hF;
    tick();
    nChecks++;
    if (sValid !== 1'b0 || sInr !== 4'b0000)
      $display("[TB] FAIL mid_reset_quiet: got valid=%b rdy=%b want 0/0000", sValid, sInr);
    else nPass++;
    reset = 1'b0;
    tick();
    nChecks++;
    if (sValid !== 1'b0) $display("[TB] FAIL mid_after_reset_idle: got valid=%b want 0", sValid);
    else nPass++;
    tick();
    nChecks++;
    if (sHs !== 1'b1 || sId !== 2'd0 || sPx !== 16'h0010)
      $display("[TB] FAIL mid_first_grant: got hs=%b id=%0d px=%h want 1/0/0010", sHs, sId, sPx);
    else nPass++;
  endtask

  task automatic test_watchdog();
    do_reset();
    inValid  = 4'b1000;
    outReady = 1'b1;
    tick();
    for (int p = 0; p < 5; p++) begin
      tick();
      nChecks++;
      if (sHs !== 1'b1 || sId !== 2'd3 || sPx !== {8'd3, 8'(p)})
        $display("[TB] FAIL wd_pixel %0d: got hs=%b id=%0d px=%h want 1/3/%h", p, sHs, sId, sPx, {8'd3, 8'(p)});
      else nPass++;
    end
    inValid = 4'b0001;
`ifdef CROP_ARB_WATCHDOG_EN
    for (int c = 1; c <= TMO; c++) begin
      tick();
      nChecks++;
      if (sValid !== 1'b0 || sInr !== 4'b1000 || sErr !== 1'b0)
        $display("[TB] FAIL wd_stall cyc %0d: got valid=%b rdy=%b err=%b want 0/1000/0", c, sValid, sInr, sErr);
      else nPass++;
    end
    tick();
    nChecks++;
    if (sValid !== 1'b0 || sInr !== 4'b0000 || sErr !== 1'b1)
      $display("[TB] FAIL wd_trip: got valid=%b rdy=%b err=%b want 0/0000/1", sValid, sInr, sErr);
    else nPass++;
    tick();
    nChecks++;
    if (sHs !== 1'b1 || sId !== 2'd0 || sPx !== 16'h0000 || sLast !== 1'b0)
      $display("[TB] FAIL wd_next_grant: got hs=%b id=%0d px=%h last=%b want 1/0/0000/0", sHs, sId, sPx, sLast);
    else nPass++;
    inValid = 4'b0000;
    for (int c = 0; c < 4; c++) tick();
    nChecks++;
    if (sErr !== 1'b1) $display("[TB] FAIL wd_sticky: got err=%b want 1", sErr);
    else nPass++;
`else
    for (int c = 1; c <= TMO + 8; c++) begin
      tick();
      nChecks++;
      if (sValid !== 1'b0 || sInr !== 4'b1000 || sErr !== 1'b0)
        $display("[TB] FAIL nowd_hold cyc %0d: got valid=%b rdy=%b err=%b want 0/1000/0", c, sValid, sInr, sErr);
      else nPass++;
    end
    inValid = 4'b1001;
    tick();
    nChecks++;
    if (sHs !== 1'b1 || sId !== 2'd3 || sPx !== 16'h0305)
      $display("[TB] FAIL nowd_resume: got hs=%b id=%0d px=%h want 1/3/0305", sHs, sId, sPx);
    else nPass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_all_streams();
    test_random_flow();
    test_reset_mid_burst();
    test_watchdog();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: got still running want finished");
    $fatal(1, "[TB] time limit expired");
  end

endmodule
